if_id_register: RTL and testbench

- IF/ID pipeline register of the 5-stage MIPS-style CPU.
- Captures the fetched instruction and PC+4 each cycle and holds them on a load-use stall. On a taken branch/jump it replaces them with a bubble.
- Splits the held instruction into decode fields, including the 16-bit immediate consumed by the ID-stage sign extender.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/if_id_register_pkg.sv | 27 ++
 rtl/if_id_register_if.sv | 40 ++++
 rtl/if_id_register_sat_counter.sv | 19 +
 rtl/if_id_register.sv | 81 ++++++++
 tb/tb_if_id_register.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_register_pkg.sv
// Shared definitions for the IF/ID pipeline register: decode field positions,
// the NOP encoding, default counter width and the valid/bubble state type.
package if_id_register_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } ifid_state_e;

endpackage

// File: rtl/if_id_register_if.sv
// Signal bundle between the fetch stage (master) and the IF/ID register (slave).
// start_i/stall_i/flush_i are level-sampled on every rising clock edge; no handshake.
interface if_id_register_if
  import if_id_register_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32,
   parameter int CNT_W   = CNT_W_DEF
);
   logic               start_i;
   logic [INSTR_W-1:0] instr_i;
   logic [PC_W-1:0]    pc_plus4_i;
   logic               stall_i;
   logic               flush_i;

   logic               valid_o;
   logic [INSTR_W-1:0] instr_o;
   logic [PC_W-1:0]    pc_plus4_o;
   logic [5:0]         opcode_o;
   logic [4:0]         rs_o;
   logic [4:0]         rt_o;
   logic [4:0]         rd_o;
   logic [5:0]         funct_o;
   logic [15:0]        imm16_o;
   logic [CNT_W-1:0]   stall_cnt_o;
   logic [CNT_W-1:0]   flush_cnt_o;
   ifid_state_e        state_o;

   modport master (
      output start_i, instr_i, pc_plus4_i, stall_i, flush_i,
      input  valid_o, instr_o, pc_plus4_o, opcode_o, rs_o, rt_o, rd_o,
             funct_o, imm16_o, stall_cnt_o, flush_cnt_o, state_o
   );

   modport slave (
      input  start_i, instr_i, pc_plus4_i, stall_i, flush_i,
      output valid_o, instr_o, pc_plus4_o, opcode_o, rs_o, rt_o, rd_o,
             funct_o, imm16_o, stall_cnt_o, flush_cnt_o, state_o
   );
endinterface

// File: rtl/if_id_register_sat_counter.sv
// Enable-driven event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures instruction and PC+4, holds on stall,
// inserts a bubble on flush, splits decode fields and counts stall/flush events.
module if_id_register
  import if_id_register_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   if_id_register_if.slave bus
);

   ifid_state_e        state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               stall_apply;
   logic               flush_apply;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_BUBBLE;
         instr_q <= INSTR_W'(NOP_INSTR);
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   // Flush outranks stall: a squashed slot must not keep a stale instruction.
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      pc_d        = pc_q;
      stall_apply = 1'b0;
      flush_apply = 1'b0;
      if (bus.start_i) begin
         if (bus.flush_i) begin
            state_d     = ST_BUBBLE;
            instr_d     = INSTR_W'(NOP_INSTR);
            pc_d        = bus.pc_plus4_i;
            flush_apply = 1'b1;
         end else if (bus.stall_i) begin
            stall_apply = 1'b1;
         end else begin
            state_d = ST_VALID;
            instr_d = bus.instr_i;
            pc_d    = bus.pc_plus4_i;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (stall_apply),
      .count (bus.stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (flush_apply),
      .count (bus.flush_cnt_o)
   );

   assign bus.state_o    = state_q;
   assign bus.valid_o    = (state_q == ST_VALID);
   assign bus.instr_o    = instr_q;
   assign bus.pc_plus4_o = pc_q;
   assign bus.opcode_o   = instr_q[OPCODE_MSB:OPCODE_LSB];
   assign bus.rs_o       = instr_q[RS_MSB:RS_LSB];
   assign bus.rt_o       = instr_q[RT_MSB:RT_LSB];
   assign bus.rd_o       = instr_q[RD_MSB:RD_LSB];
   assign bus.funct_o    = instr_q[FUNCT_MSB:FUNCT_LSB];
   assign bus.imm16_o    = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_if_id_register.sv
// Directed self-checking bench for the IF/ID pipeline register.
module tb_if_id_register;

   logic clk;
   logic rst_i;
   int   vectors;
   int   miscompares;

   if_id_register_if bus ();

   if_id_register dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_i          = 1'b0;
      bus.start_i    = 1'b1;
      bus.instr_i    = 32'h8C22_0004;
      bus.pc_plus4_i = 32'h0000_0004;
      bus.stall_i    = 1'b0;
      bus.flush_i    = 1'b0;
      #2;
      vectors++;
      if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o, bus.stall_cnt_o, bus.flush_cnt_o} !== 81'd0) begin
         miscompares++;
         $display("FAIL reset_before_edge: valid=%b instr=%h pc=%h sc=%0d fc=%0d expected all zero",
                  bus.valid_o, bus.instr_o, bus.pc_plus4_o, bus.stall_cnt_o, bus.flush_cnt_o);
      end
      step();
      step();
      vectors++;
      if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o} !== 65'd0) begin
         miscompares++;
         $display("FAIL reset_held: valid=%b instr=%h pc=%h expected all zero",
                  bus.valid_o, bus.instr_o, bus.pc_plus4_o);
      end
      rst_i = 1'b1;
      step();
      vectors++;
      if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o} !== {1'b1, 32'h8C22_0004, 32'h4}) begin
         miscompares++;
         $display("FAIL first_capture: valid=%b instr=%h pc=%h expected 1 8c220004 00000004",
                  bus.valid_o, bus.instr_o, bus.pc_plus4_o);
      end
      vectors++;
      if ({bus.opcode_o, bus.rs_o, bus.rt_o, bus.imm16_o} !== {6'h23, 5'd1, 5'd2, 16'h0004}) begin
         miscompares++;
         $display("FAIL first_fields: op=%h rs=%0d rt=%0d imm=%h expected 23 1 2 0004",
                  bus.opcode_o, bus.rs_o, bus.rt_o, bus.imm16_o);
      end
   endtask

   task automatic test_stall();
      logic held_ok;
      bus.instr_i    = 32'h0043_0820;
      bus.pc_plus4_i = 32'h0000_0010;
      step();
      vectors++;
      if ({bus.rs_o, bus.rt_o, bus.rd_o, bus.funct_o, bus.opcode_o} !== {5'd2, 5'd3, 5'd1, 6'h20, 6'h00}) begin
         miscompares++;
         $display("FAIL rtype_fields: rs=%0d rt=%0d rd=%0d funct=%h op=%h expected 2 3 1 20 00",
                  bus.rs_o, bus.rt_o, bus.rd_o, bus.funct_o, bus.opcode_o);
      end
      bus.stall_i = 1'b1;
      held_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.instr_i    = 32'hDEAD_0000 + 32'(i);
         bus.pc_plus4_i = 32'h0000_0100 + 32'(i);
         step();
         if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o} !== {1'b1, 32'h0043_0820, 32'h10}) held_ok = 1'b0;
      end
      vectors++;
      if (held_ok !== 1'b1 || bus.instr_o !== 32'h0043_0820) begin
         miscompares++;
         $display("FAIL stall_hold: instr=%h pc=%h valid=%b expected 00430820 00000010 1",
                  bus.instr_o, bus.pc_plus4_o, bus.valid_o);
      end
      vectors++;
      if (bus.stall_cnt_o !== 8'd3) begin
         miscompares++;
         $display("FAIL stall_count: got %0d expected 3", bus.stall_cnt_o);
      end
      bus.stall_i = 1'b0;
   endtask

   task automatic test_flush();
      bus.flush_i    = 1'b1;
      bus.instr_i    = 32'h2001_FFFF;
      bus.pc_plus4_i = 32'h0000_0020;
      step();
      vectors++;
      if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o} !== {1'b0, 32'h0, 32'h20}) begin
         miscompares++;
         $display("FAIL flush_bubble: valid=%b instr=%h pc=%h expected 0 00000000 00000020",
                  bus.valid_o, bus.instr_o, bus.pc_plus4_o);
      end
      vectors++;
      if ({bus.flush_cnt_o, bus.stall_cnt_o} !== {8'd1, 8'd3}) begin
         miscompares++;
         $display("FAIL flush_count: fc=%0d sc=%0d expected 1 3", bus.flush_cnt_o, bus.stall_cnt_o);
      end
      bus.flush_i    = 1'b0;
      bus.instr_i    = 32'h2001_0005;
      bus.pc_plus4_i = 32'h0000_0024;
      step();
      vectors++;
      if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o} !== {1'b1, 32'h2001_0005, 32'h24}) begin
         miscompares++;
         $display("FAIL after_flush: valid=%b instr=%h pc=%h expected 1 20010005 00000024",
                  bus.valid_o, bus.instr_o, bus.pc_plus4_o);
      end
   endtask

   task automatic test_stall_flush();
      bus.stall_i    = 1'b1;
      bus.flush_i    = 1'b1;
      bus.instr_i    = 32'h1234_5678;
      bus.pc_plus4_i = 32'h0000_0028;
      step();
      vectors++;
      if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o} !== {1'b0, 32'h0, 32'h28}) begin
         miscompares++;
         $display("FAIL both_bubble: valid=%b instr=%h pc=%h expected 0 00000000 00000028",
                  bus.valid_o, bus.instr_o, bus.pc_plus4_o);
      end
      vectors++;
      if ({bus.flush_cnt_o, bus.stall_cnt_o} !== {8'd2, 8'd3}) begin
         miscompares++;
         $display("FAIL both_counts: fc=%0d sc=%0d expected 2 3", bus.flush_cnt_o, bus.stall_cnt_o);
      end
      bus.flush_i = 1'b0;
   endtask

   task automatic test_saturation();
      logic held_ok;
      logic [7:0] cnt_251;
      logic [7:0] cnt_252;
      held_ok = 1'b1;
      cnt_251 = '0;
      cnt_252 = '0;
      bus.stall_i = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         bus.instr_i    = 32'($urandom);
         bus.pc_plus4_i = 32'($urandom);
         step();
         if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o} !== {1'b0, 32'h0, 32'h28}) held_ok = 1'b0;
         if (i == 251) cnt_251 = bus.stall_cnt_o;
         if (i == 252) cnt_252 = bus.stall_cnt_o;
      end
      vectors++;
      if (cnt_251 !== 8'd254 || cnt_252 !== 8'd255) begin
         miscompares++;
         $display("FAIL sat_reach: at 251 got %0d expected 254, at 252 got %0d expected 255",
                  cnt_251, cnt_252);
      end
      vectors++;
      if (bus.stall_cnt_o !== 8'd255) begin
         miscompares++;
         $display("FAIL sat_stay: got %0d expected 255", bus.stall_cnt_o);
      end
      vectors++;
      if (held_ok !== 1'b1) begin
         miscompares++;
         $display("FAIL long_stall_hold: outputs changed during stall, now instr=%h pc=%h expected 00000000 00000028",
                  bus.instr_o, bus.pc_plus4_o);
      end
      bus.stall_i = 1'b0;
   endtask

   task automatic test_start_async_reset();
      bus.start_i    = 1'b0;
      bus.stall_i    = 1'b1;
      bus.instr_i    = 32'hCAFE_BABE;
      bus.pc_plus4_i = 32'h0000_0040;
      step();
      bus.stall_i = 1'b0;
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      step();
      vectors++;
      if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o, bus.stall_cnt_o, bus.flush_cnt_o} !==
          {1'b0, 32'h0, 32'h28, 8'd255, 8'd2}) begin
         miscompares++;
         $display("FAIL start_freeze: valid=%b instr=%h pc=%h sc=%0d fc=%0d expected 0 00000000 00000028 255 2",
                  bus.valid_o, bus.instr_o, bus.pc_plus4_o, bus.stall_cnt_o, bus.flush_cnt_o);
      end
      bus.start_i    = 1'b1;
      bus.instr_i    = 32'hAABB_CCDD;
      bus.pc_plus4_i = 32'h0000_0030;
      step();
      vectors++;
      if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o} !== {1'b1, 32'hAABB_CCDD, 32'h30}) begin
         miscompares++;
         $display("FAIL restart_capture: valid=%b instr=%h pc=%h expected 1 aabbccdd 00000030",
                  bus.valid_o, bus.instr_o, bus.pc_plus4_o);
      end
      bus.stall_i = 1'b1;
      #2;
      rst_i = 1'b0;
      #1;
      vectors++;
      if ({bus.valid_o, bus.instr_o, bus.pc_plus4_o, bus.stall_cnt_o, bus.flush_cnt_o} !== 81'd0) begin
         miscompares++;
         $display("FAIL async_reset: valid=%b instr=%h pc=%h sc=%0d fc=%0d expected all zero",
                  bus.valid_o, bus.instr_o, bus.pc_plus4_o, bus.stall_cnt_o, bus.flush_cnt_o);
      end
      step();
      rst_i       = 1'b1;
      bus.stall_i = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_stall();
      test_flush();
      test_stall_flush();
      test_saturation();
      test_start_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
